// File: rtl/accum_status_pkg.sv
// Shared constants for the accumulation status stage and its bus decoder.
// Channel count, overrun counter width and status word bit positions.
package accum_status_pkg;

  localparam int NUM_CHANNELS_DEF = 12;
  localparam int OVR_CNT_W_DEF    = 8;

  localparam int STAT_ACCUM_INT_BIT = 0;
  localparam int STAT_MEAS_BIT      = 1;

endpackage

// File: rtl/accum_status_chan.sv
// One channel slice: pending dump, published new_data flag and sticky overrun.
// new_ovr flags an unread flag being overwritten in this cycle.
module accum_status_chan
  import accum_status_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic accum_enable,
  input  logic dump,
  input  logic new_data_read,
  input  logic status_read,
  output logic new_data,
  output logic overrun,
  output logic new_ovr
);

  logic pending;
  logic pub;

  // A dump arriving with accum_enable is published now, not held.
  assign pub     = pending | dump;
  assign new_ovr = accum_enable & pub & new_data & ~new_data_read;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending  <= 1'b0;
      new_data <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accum_enable)
        pending <= 1'b0;
      else if (dump)
        pending <= 1'b1;

      if (accum_enable)
        new_data <= (new_data & ~new_data_read) | pub;
      else if (new_data_read)
        new_data <= 1'b0;

      if (new_ovr)
        overrun <= 1'b1;
      else if (status_read)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/accum_status.sv
// Accumulation status/interrupt stage below the time base.
// Optional saturating overrun event counter: ACCUM_OVR_COUNT_EN.
module accum_status
  import accum_status_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int OVR_CNT_W    = OVR_CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    accum_enable,
  input  logic                    tic_enable,
  input  logic [NUM_CHANNELS-1:0] dump,
  input  logic                    status_read,
  input  logic                    new_data_read,
  output logic                    accum_int,
  output logic                    meas_status,
  output logic [NUM_CHANNELS-1:0] new_data,
  output logic [NUM_CHANNELS-1:0] overrun,
  output logic [OVR_CNT_W-1:0]    ovr_count
);

  logic [NUM_CHANNELS-1:0] new_ovr;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    accum_status_chan u_chan (
      .clk           (clk),
      .rstn          (rstn),
      .accum_enable  (accum_enable),
      .dump          (dump[i]),
      .new_data_read (new_data_read),
      .status_read   (status_read),
      .new_data      (new_data[i]),
      .overrun       (overrun[i]),
      .new_ovr       (new_ovr[i])
    );
  end

  // Set wins over the status_read clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accum_int   <= 1'b0;
      meas_status <= 1'b0;
    end else begin
      if (accum_enable)
        accum_int <= 1'b1;
      else if (status_read)
        accum_int <= 1'b0;

      if (tic_enable)
        meas_status <= 1'b1;
      else if (status_read)
        meas_status <= 1'b0;
    end
  end

`ifdef ACCUM_OVR_COUNT_EN
  localparam int PC_W  = $clog2(NUM_CHANNELS + 1);
  localparam int SUM_W = ((OVR_CNT_W > PC_W) ? OVR_CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX =
    {{(SUM_W-OVR_CNT_W){1'b0}}, {OVR_CNT_W{1'b1}}};

  logic [PC_W-1:0]      ovr_pc;
  logic [OVR_CNT_W-1:0] ovr_base;
  logic [SUM_W-1:0]     ovr_sum;

  always_comb begin
    ovr_pc = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      ovr_pc = ovr_pc + PC_W'(new_ovr[i]);
  end

  // Clear first, then add events from the same cycle.
  assign ovr_base = status_read ? '0 : ovr_count;
  assign ovr_sum  = SUM_W'(ovr_base) + SUM_W'(ovr_pc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ovr_count <= '0;
    else if (ovr_sum > CNT_MAX)
      ovr_count <= {OVR_CNT_W{1'b1}};
    else
      ovr_count <= ovr_sum[OVR_CNT_W-1:0];
  end
`else
  logic ovr_unused;
  assign ovr_unused = ^new_ovr;
  assign ovr_count  = '0;
`endif

endmodule

// File: tb/tb_accum_status.sv
// Directed test for accum_status with hand-computed expectations.
// Build with +define+ACCUM_OVR_COUNT_EN to exercise the overrun counter.
module tb_accum_status;

  logic        clk = 1'b0;
  logic        rstn;
  logic        accum_enable;
  logic        tic_enable;
  logic [11:0] dump;
  logic        status_read;
  logic        new_data_read;
  logic        accum_int;
  logic        meas_status;
  logic [11:0] new_data;
  logic [11:0] overrun;
  logic [7:0]  ovr_count;

  int checks = 0;
  int errors = 0;

`ifdef ACCUM_OVR_COUNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  accum_status dut (
    .clk           (clk),
    .rstn          (rstn),
    .accum_enable  (accum_enable),
    .tic_enable    (tic_enable),
    .dump          (dump),
    .status_read   (status_read),
    .new_data_read (new_data_read),
    .accum_int     (accum_int),
    .meas_status   (meas_status),
    .new_data      (new_data),
    .overrun       (overrun),
    .ovr_count     (ovr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic ae, input logic tic,
                       input logic [11:0] d,
                       input logic sr, input logic ndr);
    accum_enable  = ae;
    tic_enable    = tic;
    dump          = d;
    status_read   = sr;
    new_data_read = ndr;
    tick();
    accum_enable  = 1'b0;
    tic_enable    = 1'b0;
    dump          = '0;
    status_read   = 1'b0;
    new_data_read = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] cnt_exp;

  initial begin
    rstn          = 1'b0;
    accum_enable  = 1'b0;
    tic_enable    = 1'b0;
    dump          = '0;
    status_read   = 1'b0;
    new_data_read = 1'b0;
    #12;
    check("rst_int", 32'(accum_int), 32'h0);
    check("rst_meas", 32'(meas_status), 32'h0);
    check("rst_nd", 32'(new_data), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_cnt", 32'(ovr_count), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // mid-operation reset
    pulse(0, 0, 12'hFFF, 0, 0);
    pulse(1, 0, 12'h000, 0, 0);
    check("t1_nd", 32'(new_data), 32'hFFF);
    check("t1_int", 32'(accum_int), 32'h1);
    pulse(0, 0, 12'hFFF, 0, 0);
    rstn = 1'b0;
    #1;
    check("t1_async_nd", 32'(new_data), 32'h0);
    check("t1_async_int", 32'(accum_int), 32'h0);
    check("t1_async_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    check("t1_noint", 32'(accum_int), 32'h0);
    pulse(1, 0, 12'h000, 0, 0);
    check("t1_discard", 32'(new_data), 32'h0);
    check("t1_int2", 32'(accum_int), 32'h1);
    pulse(0, 0, 12'h000, 1, 0);
    check("t1_intclr", 32'(accum_int), 32'h0);

    // publish after delay
    pulse(0, 0, 12'h008, 0, 0);
    idle(4);
    pulse(1, 0, 12'h000, 0, 0);
    check("t2_nd", 32'(new_data), 32'h008);
    check("t2_int", 32'(accum_int), 32'h1);
    check("t2_meas", 32'(meas_status), 32'h0);
    pulse(0, 0, 12'h000, 1, 0);
    check("t2_intclr", 32'(accum_int), 32'h0);
    check("t2_ndkeep", 32'(new_data), 32'h008);
    pulse(0, 0, 12'h000, 0, 1);
    check("t2_ndclr", 32'(new_data), 32'h0);

    // coincident dump
    pulse(1, 0, 12'h001, 0, 0);
    check("t3_nd", 32'(new_data), 32'h001);
    pulse(0, 0, 12'h000, 0, 1);
    pulse(1, 0, 12'h000, 0, 0);
    check("t3_nopend", 32'(new_data), 32'h0);
    pulse(0, 0, 12'h000, 1, 0);

    // overrun
    pulse(0, 0, 12'h004, 0, 0);
    pulse(1, 0, 12'h000, 0, 0);
    check("t4_ovr0", 32'(overrun), 32'h0);
    pulse(0, 0, 12'h004, 0, 0);
    pulse(1, 0, 12'h000, 0, 0);
    check("t4_ovr", 32'(overrun), 32'h004);
    check("t4_nd", 32'(new_data), 32'h004);
    pulse(0, 0, 12'h000, 1, 0);
    check("t4_ovrclr", 32'(overrun), 32'h0);
    pulse(0, 0, 12'h000, 0, 1);
    pulse(0, 0, 12'h004, 0, 0);
    pulse(1, 0, 12'h000, 0, 0);
    pulse(0, 0, 12'h004, 0, 0);
    pulse(1, 0, 12'h000, 0, 1);
    check("t4_readovr", 32'(overrun), 32'h0);
    check("t4_readnd", 32'(new_data), 32'h004);
    pulse(0, 0, 12'h000, 1, 1);

    // new overrun wins over status_read
    pulse(0, 0, 12'h002, 0, 0);
    pulse(1, 0, 12'h000, 0, 0);
    pulse(0, 0, 12'h002, 0, 0);
    pulse(1, 0, 12'h000, 0, 0);
    check("sw_ovr1", 32'(overrun), 32'h002);
    pulse(0, 0, 12'h004, 0, 0);
    pulse(1, 0, 12'h000, 0, 0);
    check("sw_nd", 32'(new_data), 32'h006);
    check("sw_ovr2", 32'(overrun), 32'h002);
    pulse(0, 0, 12'h004, 0, 0);
    pulse(1, 0, 12'h000, 1, 0);
    check("sw_ovr3", 32'(overrun), 32'h004);
    pulse(0, 0, 12'h000, 1, 1);
    check("sw_clr", 32'(overrun), 32'h0);
    check("sw_ndclr", 32'(new_data), 32'h0);

    // set wins for int and meas
    pulse(1, 1, 12'h000, 1, 0);
    check("t5_int", 32'(accum_int), 32'h1);
    check("t5_meas", 32'(meas_status), 32'h1);
    pulse(0, 0, 12'h000, 1, 0);
    check("t5_intclr", 32'(accum_int), 32'h0);
    check("t5_measclr", 32'(meas_status), 32'h0);
    pulse(0, 1, 12'h000, 0, 0);
    check("t5_tic", 32'(meas_status), 32'h1);
    check("t5_ticint", 32'(accum_int), 32'h0);
    pulse(0, 0, 12'h000, 1, 0);

    // held dump acts as a single pulse
    dump = 12'h080;
    idle(3);
    dump = '0;
    pulse(1, 0, 12'h000, 0, 0);
    check("hold_nd", 32'(new_data), 32'h080);
    check("hold_ovr", 32'(overrun), 32'h0);
    pulse(0, 0, 12'h000, 1, 1);

    // saturating overrun counter on ch5
    pulse(1, 0, 12'h020, 0, 0);
    check("t6_prime", 32'(ovr_count), 32'h0);
    for (int i = 0; i < 3; i++) pulse(1, 0, 12'h020, 0, 0);
    cnt_exp = OVR_EN ? 8'd3 : 8'd0;
    check("t6_cnt3", 32'(ovr_count), 32'(cnt_exp));
    check("t6_ovr", 32'(overrun), 32'h020);
    for (int i = 0; i < 297; i++) pulse(1, 0, 12'h020, 0, 0);
    cnt_exp = OVR_EN ? 8'd255 : 8'd0;
    check("t6_sat", 32'(ovr_count), 32'(cnt_exp));
    pulse(0, 0, 12'h000, 1, 0);
    check("t6_clr", 32'(ovr_count), 32'h0);
    pulse(1, 0, 12'h020, 1, 0);
    cnt_exp = OVR_EN ? 8'd1 : 8'd0;
    check("t6_clradd", 32'(ovr_count), 32'(cnt_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
